// File: rtl/nbody_pair_sched.sv
// Pair scheduler for one force-evaluation pass: walks every ordered (i,j), j!=i,
// drives RAM read addresses and tags each pair through a latency-matched delay line.
module nbody_pair_sched #(
  parameter int BODIES       = 512,
  parameter int IDX_W        = $clog2(BODIES),
  parameter int RAM_LATENCY  = 1,
  parameter int ACCL_LATENCY = 123
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [IDX_W:0]   num_bodies,
  output logic [IDX_W-1:0] rd_i,
  output logic [IDX_W-1:0] rd_j,
  output logic             issue_valid,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_i,
  output logic             res_first,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = RAM_LATENCY + ACCL_LATENCY;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] TWO = (IDX_W+1)'(2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] vld_q, first_q, last_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  logic           start_acc, first_w, last_w, last_pair;
  logic [IDX_W:0] i_x, j_x, j_inc, j_cand;

  // Index arithmetic is one bit wider than the address so that N=BODIES never wraps.
  always_comb begin
    i_x       = {1'b0, i_q};
    j_x       = {1'b0, j_q};
    first_w   = (j_x == ((i_x == '0) ? ONE : '0));
    last_w    = (j_x == ((i_x == n_q - ONE) ? n_q - TWO : n_q - ONE));
    last_pair = (i_x == n_q - ONE) && last_w;
    j_inc     = j_x + ONE;
    j_cand    = (j_inc == i_x) ? j_inc + ONE : j_inc;
  end

  always_comb begin
    issue_valid = (state_q == ISSUE) && !hold;
    start_acc   = (state_q == IDLE) && start && !abort;
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);

    i_d = i_q;
    j_d = j_q;
    n_d = n_q;
    if (start_acc) begin
      n_d = num_bodies;
      if (num_bodies >= TWO) begin
        i_d = '0;
        j_d = IDX_W'(1);
      end
    end else if (issue_valid && !last_pair) begin
      if (j_cand < n_q) begin
        j_d = j_cand[IDX_W-1:0];
      end else begin
        i_d = i_q + IDX_W'(1);
        j_d = (i_d == '0) ? IDX_W'(1) : '0;
      end
    end

    cnt_d = cnt_q;
    case ({issue_valid, res_valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (abort) cnt_d = '0;

    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = (num_bodies >= TWO) ? ISSUE : FIN;
      ISSUE:   if (issue_valid && last_pair) state_d = DRAIN;
      DRAIN:   if (cnt_d == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag delay line shifts every cycle, hold or not; abort only kills the valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) idx_q[k] <= '0;
    end else begin
      vld_q[0]   <= issue_valid && !abort;
      first_q[0] <= first_w;
      last_q[0]  <= last_w;
      idx_q[0]   <= i_q;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_q[k]   <= vld_q[k-1] && !abort;
        first_q[k] <= first_q[k-1];
        last_q[k]  <= last_q[k-1];
        idx_q[k]   <= idx_q[k-1];
      end
    end
  end

  assign rd_i      = i_q;
  assign rd_j      = j_q;
  assign res_valid = vld_q[DEPTH-1];
  assign res_i     = idx_q[DEPTH-1];
  assign res_first = first_q[DEPTH-1];
  assign res_last  = last_q[DEPTH-1];

endmodule

// File: tb/tb_nbody_pair_sched.sv
// Bench for nbody_pair_sched: directed passes plus randomized hold/noise, checked
// against a pair-list/result-queue model of one force-evaluation pass.
module tb_nbody_pair_sched;

  localparam int BODIES = 8;
  localparam int IDX_W  = 3;
  localparam int RAM_L  = 1;
  localparam int ACCL_L = 4;
  localparam int D      = RAM_L + ACCL_L;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [IDX_W:0]   num_bodies = '0;
  logic [IDX_W-1:0] rd_i, rd_j, res_i;
  logic             issue_valid, res_valid, res_first, res_last, busy, done;

  always #5 clk = ~clk;

  nbody_pair_sched #(
    .BODIES(BODIES), .IDX_W(IDX_W), .RAM_LATENCY(RAM_L), .ACCL_LATENCY(ACCL_L)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .num_bodies(num_bodies), .rd_i(rd_i), .rd_j(rd_j), .issue_valid(issue_valid),
    .res_valid(res_valid), .res_i(res_i), .res_first(res_first), .res_last(res_last),
    .busy(busy), .done(done)
  );

  typedef struct { int i; int j; bit f; bit l; } pair_t;
  typedef struct { int due; int i; bit f; bit l; } res_t;

  pair_t pq[$];
  res_t  rq[$];
  bit    busy_exp = 1'b0;
  int    done_due = -1;
  int    cyc = 0, tests = 0, fails = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected pair order: i ascending, j ascending, first/last by position within i.
  task automatic build(input int n);
    pair_t p;
    int    c;
    pq.delete();
    for (int i = 0; i < n; i++) begin
      c = 0;
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          p.i = i; p.j = j; p.f = (c == 0); p.l = (c == n - 2);
          pq.push_back(p);
          c++;
        end
      end
    end
  endtask

  task automatic cycle(input bit h, input bit st, input bit ab, input int nb);
    bit    exp_iv, exp_rv, idle_now;
    pair_t p;
    res_t  r;
    @(negedge clk);
    cyc++;
    hold = h; start = st; abort = ab; num_bodies = nb[IDX_W:0];
    #1;
    exp_iv = busy_exp && (pq.size() > 0) && !h;
    chk("issue_valid", issue_valid, exp_iv);
    if (busy_exp && pq.size() > 0) begin
      chk("rd_i", rd_i, pq[0].i);
      chk("rd_j", rd_j, pq[0].j);
    end
    if (exp_iv) begin
      p = pq.pop_front();
      r.due = cyc + D; r.i = p.i; r.f = p.f; r.l = p.l;
      rq.push_back(r);
    end
    exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
    chk("res_valid", res_valid, exp_rv);
    if (exp_rv) begin
      r = rq.pop_front();
      chk("res_i", res_i, r.i);
      chk("res_first", res_first, r.f);
      chk("res_last", res_last, r.l);
    end
    if (busy_exp && done_due < 0 && pq.size() == 0 && rq.size() == 0) done_due = cyc + 1;
    chk("done", done, cyc == done_due);
    chk("busy", busy, busy_exp);
    if (done === 1'b1) done_cnt++;
    idle_now = !busy_exp;
    if (cyc == done_due) begin
      busy_exp = 1'b0;
      done_due = -1;
    end
    if (ab) begin
      busy_exp = 1'b0;
      pq.delete();
      rq.delete();
      done_due = -1;
    end else if (st && idle_now) begin
      busy_exp = 1'b1;
      build(nb);
      if (nb < 2) done_due = cyc + 1;
    end
  endtask

  task automatic wait_idle(input int hold_pct, input bit noise, input int n, input int budget);
    int k;
    k = 0;
    while (busy_exp && k < budget) begin
      cycle($urandom_range(0, 99) < hold_pct,
            noise && ($urandom_range(0, 3) == 0), 1'b0,
            noise ? int'($urandom_range(0, BODIES)) : n);
      k++;
    end
    if (k >= budget) begin
      fails++;
      $error("FAIL pass_timeout: observed %0d cycles expected below %0d", k, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_i", rd_i, 0);
    chk("rst_rd_j", rd_j, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_flags", {res_first, res_last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    cycle(0, 0, 0, 0);

    cycle(0, 1, 0, 3);                 // N=3 full pass
    wait_idle(0, 0, 3, 200);

    cycle(0, 1, 0, 1);                 // N=1 and N=0: no pairs
    wait_idle(0, 0, 1, 20);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    wait_idle(0, 0, 0, 20);

    cycle(0, 1, 0, 4);                 // N=4, hold on ISSUE cycles 2-3
    cycle(0, 0, 0, 4);
    cycle(1, 0, 0, 4);
    cycle(1, 0, 0, 4);
    wait_idle(0, 0, 4, 200);

    cycle(0, 1, 0, BODIES);            // N=BODIES
    wait_idle(0, 0, BODIES, 400);
    chk("done_count_a", done_cnt, 5);

    cycle(0, 1, 0, 5);                 // N=5, abort with 3 in flight
    repeat (3) cycle(0, 0, 0, 5);
    cycle(0, 0, 1, 5);
    repeat (12) cycle(0, 0, 0, 5);
    chk("done_after_abort", done_cnt, 5);
    cycle(0, 1, 0, 5);
    wait_idle(0, 0, 5, 300);
    chk("done_count_b", done_cnt, 6);

    cycle(0, 1, 1, 4);                 // start with abort in IDLE: stays idle
    cycle(0, 0, 0, 4);
    chk("start_abort_busy", busy, 0);

    cycle(0, 1, 0, 6);                 // N=6 with stray starts and num_bodies churn
    wait_idle(20, 1, 6, 500);
    chk("done_count_c", done_cnt, 7);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, BODIES);
      cycle(0, 0, 0, n);
      cycle(0, 1, 0, n);
      wait_idle($urandom_range(0, 50), 1'b1, n, 1000);
    end
    repeat (3) cycle(0, 0, 0, 0);
    chk("done_total", done_cnt, 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
